instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage of the multi-cycle MIPS datapath, directly upstream of the control unit.
- Owns the PC register and the instruction register (IR).
- Issues instruction-memory reads when the control unit asserts MemReadI.
- Applies the control unit's PCWrite/PCSrc updates and supplies the opcode/funct and operand fields that the control unit and datapath decode.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word-aligned)
MAX_WAIT, 16, cycles a fetch may wait for imem_valid before timeout (range 2..255)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
MemReadI  in  1  fetch request strobe from control unit
IRWrite  in  1  IR load enable from control unit; a fetch starts only when MemReadI=1 and IRWrite=1
PCWrite  in  1  PC update enable from control unit
PCSrc  in  2  next-PC select: 00 jump, 01 alu_result, 10 branch_target, 11 hold
alu_result  in  32  ALU result (PC+4 during fetch)
branch_target  in  32  ALUOut branch target
imem_rdata  in  32  instruction memory read data
imem_valid  in  1  imem_rdata valid for the current request
imem_req  out  1  instruction memory read request
imem_addr  out  32  instruction memory byte address
pc  out  32  current PC register
instr  out  32  instruction register
opcode  out  6  instr[31:26]
funct  out  6  instr[5:0]
rs  out  5  instr[25:21]
rt  out  5  instr[20:16]
rd  out  5  instr[15:11]
shamt  out  5  instr[10:6]
imm_sext  out  32  sign-extended instr[15:0]
fetch_busy  out  1  fetch outstanding; the integration stalls the control unit while this is high
fetch_err  out  1  sticky error flag (timeout or misaligned PC write)

Behaviour:
- Reset (synchronous, takes priority over all else):
  - pc=RESET_PC, instr=0, state=IDLE, wait_cnt=0, req_addr=0, fetch_err=0.
  - Outputs then: imem_req=0, fetch_busy=0.
  - Reset during WAIT abandons the fetch. The instruction memory must reset on the same reset.
- FSM states: IDLE, WAIT.
- IDLE:
  - imem_addr=pc (combinational).
  - imem_req=MemReadI&IRWrite (combinational).
  - On request with imem_valid=1 (zero-wait): instr<=imem_rdata at this edge; stay IDLE; fetch_busy=0.
  - On request with imem_valid=0: req_addr<=pc, wait_cnt<=1, go WAIT; fetch_busy=1 combinationally this cycle.
- WAIT:
  - imem_req=1, imem_addr=req_addr, fetch_busy=1.
  - On imem_valid=1: instr<=imem_rdata, wait_cnt<=0, go IDLE.
  - Else if wait_cnt==MAX_WAIT-1: instr<=32'h0000_0000 (NOP), fetch_err<=1, wait_cnt<=0, go IDLE.
  - Else wait_cnt<=wait_cnt+1.
  - MemReadI/IRWrite are ignored in WAIT; no second request is queued.
- PC update (independent of FSM, every edge with PCWrite=1):
  - 00: pc<={pc[31:28], instr[25:0], 2'b00}, using the current IR.
  - 01: pc<=alu_result.
  - 10: pc<=branch_target.
  - 11: pc holds; no error raised.
  - If the selected value has [1:0]!=0: pc<=value with [1:0] forced to 00, and fetch_err<=1.
  - A PCWrite in the same cycle as a fetch start is legal. The fetch uses the pre-update pc; req_addr was captured before the update.
- Decoded fields and imm_sext are combinational from the instr register.
- imem_valid in IDLE without a request is ignored; instr is unchanged.
- fetch_err clears only on reset.

Test Plan:
- Reset then zero-wait fetch:
  - Stimulus: reset; MemReadI=IRWrite=PCWrite=1, PCSrc=01, alu_result=4, imem_valid=1, rdata=32'h2008_0005 at pc=0.
  - Required: next cycle instr=32'h2008_0005, opcode=6'h08, rt=8, imm_sext=5, pc=4, fetch_busy never high.
- 3-cycle wait fetch:
  - Stimulus: imem_valid asserted 3 cycles after request, pc=8.
  - Required: imem_addr=8 throughout; fetch_busy high 3 cycles; instr loads on the valid edge; PCWrite in the request cycle gives pc=alu_result while imem_addr stays 8.
- Timeout:
  - Stimulus: MAX_WAIT=4, imem_valid held 0.
  - Required: return to IDLE 4 cycles after the request; instr=0; fetch_err=1 and remains 1 across later good fetches.
- Jump and branch:
  - Stimulus: pc=32'h1000_0010, instr=32'h0800_0040, PCWrite, PCSrc=00. Then PCSrc=10 with branch_target=32'h0000_0100.
  - Required: pc=32'h1000_0100, then pc=32'h0000_0100.
- Misaligned write and hold:
  - Stimulus: PCSrc=01 with alu_result=32'h0000_0006. Then PCSrc=11.
  - Required: pc=32'h0000_0004 and fetch_err=1; then pc unchanged.
- Reset mid-WAIT:
  - Stimulus: assert reset in the 2nd WAIT cycle.
  - Required: next cycle state IDLE, imem_req=0, pc=RESET_PC, instr=0, fetch_err=0.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if
// Bundles the control-unit handshake, instruction-memory bus and decoded-field
// outputs of the fetch stage.
//   slave  : fetch-unit side (takes control/imem inputs, drives PC/IR/decode)
//   master : control-unit / memory / test side (the mirror image)
interface instr_fetch_unit_if;
    logic        MemReadI;
    logic        IRWrite;
    logic        PCWrite;
    logic [1:0]  PCSrc;
    logic [31:0] alu_result;
    logic [31:0] branch_target;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [31:0] imm_sext;
    logic        fetch_busy;
    logic        fetch_err;

    modport slave (
        input  MemReadI, IRWrite, PCWrite, PCSrc, alu_result, branch_target,
               imem_rdata, imem_valid,
        output imem_req, imem_addr, pc, instr, opcode, funct, rs, rt, rd, shamt,
               imm_sext, fetch_busy, fetch_err
    );

    modport master (
        output MemReadI, IRWrite, PCWrite, PCSrc, alu_result, branch_target,
               imem_rdata, imem_valid,
        input  imem_req, imem_addr, pc, instr, opcode, funct, rs, rt, rd, shamt,
               imm_sext, fetch_busy, fetch_err
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Fetch stage of the multi-cycle MIPS datapath. Owns PC and IR, issues
// instruction-memory reads on MemReadI&IRWrite, waits up to MAX_WAIT cycles for
// imem_valid, and applies PCWrite/PCSrc updates.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset
//   io_bus : instr_fetch_unit_if.slave (control inputs, imem bus, PC/IR/decode)
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    instr_fetch_unit_if.slave     io_bus
);
    typedef enum logic [0:0] {IDLE, WAIT} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_req_addr;
    logic [7:0]  r_wait_cnt;
    logic        r_fetch_err;

    logic        w_start;
    logic        w_idle;
    logic [31:0] w_next_pc;
    logic        w_pc_upd;
    logic        w_misalign;

    assign w_start = io_bus.MemReadI & io_bus.IRWrite;
    assign w_idle  = (r_state == IDLE);

    always_comb begin
        w_next_pc = r_pc;
        case (io_bus.PCSrc)
            2'b00:   w_next_pc = {r_pc[31:28], r_instr[25:0], 2'b00};
            2'b01:   w_next_pc = io_bus.alu_result;
            2'b10:   w_next_pc = io_bus.branch_target;
            default: w_next_pc = r_pc;
        endcase
    end

    assign w_pc_upd   = io_bus.PCWrite & (io_bus.PCSrc != 2'b11);
    assign w_misalign = (w_next_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC;
            r_instr     <= 32'h0000_0000;
            r_req_addr  <= 32'h0000_0000;
            r_wait_cnt  <= 8'd0;
            r_fetch_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        if (io_bus.imem_valid) begin
                            r_instr <= io_bus.imem_rdata;
                        end else begin
                            // Latch the pre-update PC so a concurrent PCWrite
                            // cannot move the outstanding fetch.
                            r_req_addr <= r_pc;
                            r_wait_cnt <= 8'd1;
                            r_state    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (io_bus.imem_valid) begin
                        r_instr    <= io_bus.imem_rdata;
                        r_wait_cnt <= 8'd0;
                        r_state    <= IDLE;
                    end else if (r_wait_cnt == 8'(MAX_WAIT - 1)) begin
                        // Timed out: retire a NOP and flag the error.
                        r_instr     <= 32'h0000_0000;
                        r_fetch_err <= 1'b1;
                        r_wait_cnt  <= 8'd0;
                        r_state     <= IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_pc_upd) begin
                r_pc <= {w_next_pc[31:2], 2'b00};
                if (w_misalign) begin
                    r_fetch_err <= 1'b1;
                end
            end
        end
    end

    assign io_bus.imem_req   = w_idle ? w_start : 1'b1;
    assign io_bus.imem_addr  = w_idle ? r_pc : r_req_addr;
    assign io_bus.fetch_busy = ~w_idle | (w_start & ~io_bus.imem_valid);
    assign io_bus.fetch_err  = r_fetch_err;
    assign io_bus.pc         = r_pc;
    assign io_bus.instr      = r_instr;
    assign io_bus.opcode     = r_instr[31:26];
    assign io_bus.rs         = r_instr[25:21];
    assign io_bus.rt         = r_instr[20:16];
    assign io_bus.rd         = r_instr[15:11];
    assign io_bus.shamt      = r_instr[10:6];
    assign io_bus.funct      = r_instr[5:0];
    assign io_bus.imm_sext   = {{16{r_instr[15]}}, r_instr[15:0]};
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
// Directed scenarios followed by a randomized run; every cycle the DUT is
// compared against a transaction-level model of the fetch stage.
module tb_instr_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          MAXW   = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    instr_fetch_unit_if bus ();

    instr_fetch_unit #(
        .RESET_PC (RST_PC),
        .MAX_WAIT (MAXW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Model state: one outstanding fetch at most, tracked by address and age.
    bit          m_known = 1'b0;
    logic [31:0] m_pc, m_instr, m_paddr;
    bit          m_err, m_pending;
    int          m_waited;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic start;
        if (!m_known) return;
        start = bus.MemReadI && bus.IRWrite;
        chk("pc", bus.pc, m_pc);
        chk("instr", bus.instr, m_instr);
        chk("err", 32'(bus.fetch_err), 32'(m_err));
        chk("req", 32'(bus.imem_req), m_pending ? 32'd1 : 32'(start));
        chk("addr", bus.imem_addr, m_pending ? m_paddr : m_pc);
        chk("busy", 32'(bus.fetch_busy), 32'(m_pending || (start && !bus.imem_valid)));
        chk("opcode", 32'(bus.opcode), 32'(m_instr >> 26));
        chk("rs", 32'(bus.rs), (m_instr >> 21) % 32);
        chk("rt", 32'(bus.rt), (m_instr >> 16) % 32);
        chk("rd", 32'(bus.rd), (m_instr >> 11) % 32);
        chk("shamt", 32'(bus.shamt), (m_instr >> 6) % 32);
        chk("funct", 32'(bus.funct), m_instr % 64);
        chk("imm", bus.imm_sext, 32'($signed(m_instr[15:0])));
    endtask

    task automatic model_edge();
        logic [31:0] v, old_pc, old_instr;
        if (reset) begin
            m_known = 1'b1; m_pc = RST_PC; m_instr = 32'h0; m_err = 1'b0;
            m_pending = 1'b0; m_waited = 0; m_paddr = 32'h0;
            return;
        end
        old_pc = m_pc;
        old_instr = m_instr;
        if (m_pending) begin
            if (bus.imem_valid) begin
                m_instr = bus.imem_rdata; m_pending = 1'b0;
            end else begin
                m_waited++;
                if (m_waited >= MAXW) begin
                    m_instr = 32'h0; m_err = 1'b1; m_pending = 1'b0;
                end
            end
        end else if (bus.MemReadI && bus.IRWrite) begin
            if (bus.imem_valid) m_instr = bus.imem_rdata;
            else begin
                m_pending = 1'b1; m_paddr = old_pc; m_waited = 1;
            end
        end
        if (bus.PCWrite && bus.PCSrc != 2'd3) begin
            if (bus.PCSrc == 2'd0) v = (old_pc & 32'hF000_0000) + (old_instr % (1 << 26)) * 4;
            else if (bus.PCSrc == 2'd1) v = bus.alu_result;
            else v = bus.branch_target;
            if (v % 4 != 0) m_err = 1'b1;
            m_pc = v - (v % 4);
        end
    endtask

    // Inputs are set just after a falling edge; compare, then advance one cycle.
    task automatic tick();
        #1;
        check_all();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic quiet();
        bus.MemReadI = 0; bus.IRWrite = 0; bus.PCWrite = 0; bus.PCSrc = 2'b11;
        bus.imem_valid = 0;
    endtask

    initial begin
        quiet();
        bus.alu_result = 0; bus.branch_target = 0; bus.imem_rdata = 0;
        @(negedge clk);

        // Reset, then zero-wait fetch with PC+4
        reset = 1; tick(); reset = 0;
        chk("rst_pc", bus.pc, RST_PC);
        chk("rst_instr", bus.instr, 32'h0);
        bus.MemReadI = 1; bus.IRWrite = 1; bus.PCWrite = 1; bus.PCSrc = 2'b01;
        bus.alu_result = 32'd4; bus.imem_valid = 1; bus.imem_rdata = 32'h2008_0005;
        #1 chk("t1_busy", 32'(bus.fetch_busy), 32'd0);
        chk("t1_addr", bus.imem_addr, 32'h0);
        tick();
        quiet();
        chk("t1_instr", bus.instr, 32'h2008_0005);
        chk("t1_opcode", 32'(bus.opcode), 32'h08);
        chk("t1_rt", 32'(bus.rt), 32'd8);
        chk("t1_imm", bus.imm_sext, 32'd5);
        chk("t1_pc", bus.pc, 32'd4);

        // Three-cycle fetch at pc=8 with a PCWrite in the request cycle
        bus.PCWrite = 1; bus.PCSrc = 2'b01; bus.alu_result = 32'd8; tick();
        bus.MemReadI = 1; bus.IRWrite = 1; bus.alu_result = 32'd12;
        #1 chk("t2_addr0", bus.imem_addr, 32'd8);
        chk("t2_busy0", 32'(bus.fetch_busy), 32'd1);
        tick();
        quiet();
        chk("t2_pc", bus.pc, 32'd12);
        #1 chk("t2_addr1", bus.imem_addr, 32'd8);
        chk("t2_busy1", 32'(bus.fetch_busy), 32'd1);
        tick();
        bus.imem_valid = 1; bus.imem_rdata = 32'h8C09_FFF0;
        #1 chk("t2_addr2", bus.imem_addr, 32'd8);
        chk("t2_busy2", 32'(bus.fetch_busy), 32'd1);
        tick();
        quiet();
        chk("t2_instr", bus.instr, 32'h8C09_FFF0);
        chk("t2_imm", bus.imm_sext, 32'hFFFF_FFF0);
        chk("t2_busy3", 32'(bus.fetch_busy), 32'd0);

        // Timeout: valid never arrives; MemReadI held high is ignored in WAIT
        bus.MemReadI = 1; bus.IRWrite = 1; tick();
        for (int i = 0; i < MAXW - 1; i++) begin
            chk("t3_wait_busy", 32'(bus.fetch_busy), 32'd1);
            tick();
        end
        quiet();
        #1 chk("t3_busy", 32'(bus.fetch_busy), 32'd0);
        chk("t3_instr", bus.instr, 32'h0);
        chk("t3_err", 32'(bus.fetch_err), 32'd1);
        bus.MemReadI = 1; bus.IRWrite = 1; bus.imem_valid = 1; bus.imem_rdata = 32'h0000_0020;
        tick();
        quiet();
        chk("t3_err_sticky", 32'(bus.fetch_err), 32'd1);
        chk("t3_instr2", bus.instr, 32'h0000_0020);

        // Jump then branch
        reset = 1; tick(); reset = 0;
        chk("t4_err_clr", 32'(bus.fetch_err), 32'd0);
        bus.MemReadI = 1; bus.IRWrite = 1; bus.imem_valid = 1; bus.imem_rdata = 32'h0800_0040;
        bus.PCWrite = 1; bus.PCSrc = 2'b01; bus.alu_result = 32'h1000_0010;
        tick();
        quiet();
        chk("t4_pc0", bus.pc, 32'h1000_0010);
        bus.PCWrite = 1; bus.PCSrc = 2'b00; tick();
        chk("t4_jump", bus.pc, 32'h1000_0100);
        bus.PCSrc = 2'b10; bus.branch_target = 32'h0000_0100; tick();
        chk("t4_branch", bus.pc, 32'h0000_0100);
        chk("t4_err", 32'(bus.fetch_err), 32'd0);

        // Misaligned write, then hold
        bus.PCSrc = 2'b01; bus.alu_result = 32'h0000_0006; tick();
        chk("t5_pc", bus.pc, 32'h0000_0004);
        chk("t5_err", 32'(bus.fetch_err), 32'd1);
        bus.PCSrc = 2'b11; bus.alu_result = 32'hFFFF_FFF0; tick();
        chk("t5_hold", bus.pc, 32'h0000_0004);

        // Reset in the second WAIT cycle
        quiet();
        bus.MemReadI = 1; bus.IRWrite = 1; tick();
        quiet(); tick();
        reset = 1; tick(); reset = 0;
        #1 chk("t6_req", 32'(bus.imem_req), 32'd0);
        chk("t6_busy", 32'(bus.fetch_busy), 32'd0);
        chk("t6_pc", bus.pc, RST_PC);
        chk("t6_instr", bus.instr, 32'h0);
        chk("t6_err", 32'(bus.fetch_err), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            bus.MemReadI = ($urandom_range(0, 2) != 0);
            bus.IRWrite = ($urandom_range(0, 3) != 0);
            bus.PCWrite = ($urandom_range(0, 1) == 1);
            bus.PCSrc = 2'($urandom_range(0, 3));
            bus.alu_result = $urandom & 32'hFFFF_FFFC;
            bus.branch_target = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 31) == 0) bus.alu_result[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 31) == 0) bus.branch_target[0] = 1'b1;
            bus.imem_valid = ($urandom_range(0, 2) == 0);
            bus.imem_rdata = $urandom;
            tick();
        end
        reset = 0;
        quiet();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
